// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice path: datapath widths,
// allocator FSM state encoding and request op encoding.
package synth_pkg;

  localparam int C_REG_WIDTH  = 32;
  localparam int C_NOTE_WIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOOKUP    = 2'd1,
    ST_STEAL_GAP = 2'd2,
    ST_ASSIGN    = 2'd3
  } alloc_state_e;

  localparam logic OP_ON  = 1'b1;
  localparam logic OP_OFF = 1'b0;

endpackage

// File: rtl/voice_allocator_lru_rank.sv
// Age ranking for the voice allocator: rank 0 is the most recently assigned
// voice, rank C_VOICES-1 the oldest (the steal victim).
module lru_rank #(
  parameter int C_VOICES = 4,
  parameter int IDX_W    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             upd,
  input  logic [IDX_W-1:0]                 tgt,
  output logic [C_VOICES-1:0][IDX_W-1:0]   rank,
  output logic [IDX_W-1:0]                 victim
);
  import synth_pkg::*;

  logic [C_VOICES-1:0][IDX_W-1:0] rank_q, rank_d;

  // Move-to-front: only voices younger than the target age by one step,
  // which keeps the ranks a permutation.
  always_comb begin
    rank_d = rank_q;
    if (upd) begin
      for (int v = 0; v < C_VOICES; v++) begin
        if (v == int'(tgt)) begin
          rank_d[v] = '0;
        end else if (rank_q[v] < rank_q[tgt]) begin
          rank_d[v] = rank_q[v] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int v = 0; v < C_VOICES; v++) begin
      if (rank_q[v] == IDX_W'(C_VOICES - 1)) begin
        victim = IDX_W'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < C_VOICES; v++) begin
        rank_q[v] <= IDX_W'(v);
      end
    end else begin
      rank_q <= rank_d;
    end
  end

  assign rank = rank_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off requests onto C_VOICES voice
// slices. `define VOICE_STEAL_EN to steal the oldest voice when all are busy;
// otherwise such note-ons are dropped.
module voice_allocator #(
  parameter int C_VOICES     = 4,
  parameter int C_REG_WIDTH  = synth_pkg::C_REG_WIDTH,
  parameter int C_NOTE_WIDTH = synth_pkg::C_NOTE_WIDTH,
  parameter int C_STEAL_LEN  = 16
) (
  input  logic                             Sys_clk,
  input  logic                             Syn_rst_n,
  input  logic                             Req_valid,
  output logic                             Req_ready,
  input  logic                             Req_on,
  input  logic [C_NOTE_WIDTH-1:0]          Req_note,
  input  logic [C_REG_WIDTH-1:0]           Req_freq,
  output logic [C_VOICES*C_REG_WIDTH-1:0]  Voice_freq,
  output logic [C_VOICES*C_NOTE_WIDTH-1:0] Voice_note,
  output logic [C_VOICES-1:0]              Voice_key,
  output logic                             Stolen,
  output logic                             Dropped
);
  import synth_pkg::*;

  localparam int IDX_W = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;

  alloc_state_e                          state_q, state_d;
  logic                                  ready_q, ready_d;
  logic                                  pulse_q, pulse_d;
  logic                                  req_on_q, req_on_d;
  logic [C_NOTE_WIDTH-1:0]               req_note_q, req_note_d;
  logic [C_REG_WIDTH-1:0]                req_freq_q, req_freq_d;
  logic [IDX_W-1:0]                      tgt_q, tgt_d;
  logic [C_VOICES-1:0][C_REG_WIDTH-1:0]  voice_freq_q, voice_freq_d;
  logic [C_VOICES-1:0][C_NOTE_WIDTH-1:0] voice_note_q, voice_note_d;
  logic [C_VOICES-1:0]                   voice_key_q, voice_key_d;

  logic                                  hit, free_found;
  logic [IDX_W-1:0]                      hit_idx, free_idx, free_rank;
  logic [C_VOICES-1:0][IDX_W-1:0]        rank;
  logic [IDX_W-1:0]                      victim_idx;
  logic                                  rank_upd;

`ifdef VOICE_STEAL_EN
  localparam int CNT_W = $clog2(C_STEAL_LEN + 1);
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
`else
  logic                                  unused_victim;
  assign unused_victim = ^victim_idx;
`endif

  lru_rank #(
    .C_VOICES (C_VOICES),
    .IDX_W    (IDX_W)
  ) u_lru_rank (
    .clk    (Sys_clk),
    .rst_n  (Syn_rst_n),
    .upd    (rank_upd),
    .tgt    (tgt_q),
    .rank   (rank),
    .victim (victim_idx)
  );

  // Free voice: highest rank among released voices; strict '>' keeps the
  // lower index on a tie.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    free_rank  = '0;
    for (int v = 0; v < C_VOICES; v++) begin
      if (!hit && voice_key_q[v] && (voice_note_q[v] == req_note_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(v);
      end
      if (!voice_key_q[v] && (!free_found || (rank[v] > free_rank))) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(v);
        free_rank  = rank[v];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    pulse_d      = 1'b0;
    req_on_d     = req_on_q;
    req_note_d   = req_note_q;
    req_freq_d   = req_freq_q;
    tgt_d        = tgt_q;
    voice_freq_d = voice_freq_q;
    voice_note_d = voice_note_q;
    voice_key_d  = voice_key_q;
    rank_upd     = 1'b0;
`ifdef VOICE_STEAL_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (Req_valid && ready_q) begin
          req_on_d   = Req_on;
          req_note_d = Req_note;
          req_freq_d = Req_freq;
          ready_d    = 1'b0;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (req_on_q == OP_OFF) begin
          // Release only the gate; freq and note stay for the release tail.
          if (hit) voice_key_d[hit_idx] = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (hit) begin
          tgt_d   = hit_idx;
          state_d = ST_ASSIGN;
        end else if (free_found) begin
          tgt_d   = free_idx;
          state_d = ST_ASSIGN;
        end else begin
`ifdef VOICE_STEAL_EN
          tgt_d                   = victim_idx;
          voice_key_d[victim_idx] = 1'b0;
          pulse_d                 = 1'b1;
          cnt_d                   = '0;
          state_d                 = ST_STEAL_GAP;
`else
          pulse_d = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
`endif
        end
      end
      ST_STEAL_GAP: begin
`ifdef VOICE_STEAL_EN
        if (cnt_q == CNT_W'(C_STEAL_LEN - 1)) begin
          state_d = ST_ASSIGN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        ready_d = 1'b1;
        state_d = ST_IDLE;
`endif
      end
      ST_ASSIGN: begin
        voice_freq_d[tgt_q] = req_freq_q;
        voice_note_d[tgt_q] = req_note_q;
        voice_key_d[tgt_q]  = 1'b1;
        rank_upd            = 1'b1;
        ready_d             = 1'b1;
        state_d             = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Sys_clk) begin
    if (!Syn_rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      pulse_q      <= 1'b0;
      req_on_q     <= 1'b0;
      req_note_q   <= '0;
      req_freq_q   <= '0;
      tgt_q        <= '0;
      voice_freq_q <= '0;
      voice_note_q <= '0;
      voice_key_q  <= '0;
`ifdef VOICE_STEAL_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      pulse_q      <= pulse_d;
      req_on_q     <= req_on_d;
      req_note_q   <= req_note_d;
      req_freq_q   <= req_freq_d;
      tgt_q        <= tgt_d;
      voice_freq_q <= voice_freq_d;
      voice_note_q <= voice_note_d;
      voice_key_q  <= voice_key_d;
`ifdef VOICE_STEAL_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign Req_ready  = ready_q;
  assign Voice_freq = voice_freq_q;
  assign Voice_note = voice_note_q;
  assign Voice_key  = voice_key_q;

  // One event pulse register serves whichever of Stolen/Dropped is live.
`ifdef VOICE_STEAL_EN
  assign Stolen  = pulse_q;
  assign Dropped = 1'b0;
`else
  assign Stolen  = 1'b0;
  assign Dropped = pulse_q;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a voice/age-list model predicts
// every output each cycle, plus literal checks at key points.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int RW = 32;
  localparam int NW = 7;
  localparam int SL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic               req_on;
  logic [NW-1:0]      req_note;
  logic [RW-1:0]      req_freq;
  logic [NV*RW-1:0]   voice_freq;
  logic [NV*NW-1:0]   voice_note;
  logic [NV-1:0]      voice_key;
  logic               stolen;
  logic               dropped;

  voice_allocator #(
    .C_VOICES     (NV),
    .C_REG_WIDTH  (RW),
    .C_NOTE_WIDTH (NW),
    .C_STEAL_LEN  (SL)
  ) dut (
    .Sys_clk    (clk),
    .Syn_rst_n  (rst_n),
    .Req_valid  (req_valid),
    .Req_ready  (req_ready),
    .Req_on     (req_on),
    .Req_note   (req_note),
    .Req_freq   (req_freq),
    .Voice_freq (voice_freq),
    .Voice_note (voice_note),
    .Voice_key  (voice_key),
    .Stolen     (stolen),
    .Dropped    (dropped)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int evt_cnt  = 0;

  // Model: voice table plus an allocation-order list (front = newest).
  logic          exp_key  [NV];
  logic [NW-1:0] exp_note [NV];
  logic [RW-1:0] exp_freq [NV];
  int            age_q[$];
  logic          exp_ready, exp_stolen, exp_dropped;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [NV-1:0] exp_key_vec();
    logic [NV-1:0] k;
    for (int v = 0; v < NV; v++) k[v] = exp_key[v];
    return k;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      exp_key[v]  = 1'b0;
      exp_note[v] = '0;
      exp_freq[v] = '0;
    end
    age_q.delete();
    for (int v = 0; v < NV; v++) age_q.push_back(v);
    exp_ready   = 1'b1;
    exp_stolen  = 1'b0;
    exp_dropped = 1'b0;
  endtask

  task automatic model_assign(input int t, input logic [NW-1:0] nt, input logic [RW-1:0] fq);
    int pos;
    exp_freq[t] = fq;
    exp_note[t] = nt;
    exp_key[t]  = 1'b1;
    pos = 0;
    for (int i = 0; i < age_q.size(); i++) if (age_q[i] == t) pos = i;
    age_q.delete(pos);
    age_q.push_front(t);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 64'(req_ready), 64'(exp_ready));
      check("stolen", 64'(stolen), 64'(exp_stolen));
      check("dropped", 64'(dropped), 64'(exp_dropped));
      for (int v = 0; v < NV; v++) begin
        check($sformatf("key%0d", v), 64'(voice_key[v]), 64'(exp_key[v]));
        check($sformatf("note%0d", v), 64'(voice_note[v*NW +: NW]), 64'(exp_note[v]));
        check($sformatf("freq%0d", v), 64'(voice_freq[v*RW +: RW]), 64'(exp_freq[v]));
      end
      if (stolen || dropped) evt_cnt++;
    end
  end

  // Drives one request and advances the model edge by edge.
  task automatic send(input bit on, input logic [NW-1:0] nt, input logic [RW-1:0] fq);
    int hit, tgt;
    @(negedge clk);
    req_valid = 1'b1;
    req_on    = on;
    req_note  = nt;
    req_freq  = fq;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_on    = 1'($urandom);
    req_note  = NW'($urandom);
    req_freq  = $urandom;
    exp_ready = 1'b0;
    hit = -1;
    for (int v = 0; v < NV; v++) if (exp_key[v] && exp_note[v] == nt) hit = v;
    if (!on) begin
      @(posedge clk); #1;
      if (hit >= 0) exp_key[hit] = 1'b0;
      exp_ready = 1'b1;
    end else begin
      tgt = hit;
      if (tgt < 0) begin
        for (int i = age_q.size() - 1; i >= 0; i--) begin
          if (tgt < 0 && !exp_key[age_q[i]]) tgt = age_q[i];
        end
      end
      if (tgt >= 0) begin
        @(posedge clk);
        @(posedge clk); #1;
        model_assign(tgt, nt, fq);
        exp_ready = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        tgt = age_q[age_q.size() - 1];
        @(posedge clk); #1;
        exp_key[tgt] = 1'b0;
        exp_stolen   = 1'b1;
        @(posedge clk); #1;
        exp_stolen   = 1'b0;
        repeat (SL) @(posedge clk);
        #1;
        model_assign(tgt, nt, fq);
        exp_ready = 1'b1;
`else
        @(posedge clk); #1;
        exp_dropped = 1'b1;
        exp_ready   = 1'b1;
        @(posedge clk); #1;
        exp_dropped = 1'b0;
`endif
      end
    end
  endtask

  logic [NV*NW-1:0] notes_full;
  int               evt_base;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_on    = 1'b0;
    req_note  = '0;
    req_freq  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // First note goes to the highest-ranked free voice, voice 3.
    send(1'b1, 7'd60, 32'h1000);
    @(negedge clk);
    check("t1_key", 64'(voice_key), 64'(4'b1000));
    check("t1_freq3", 64'(voice_freq[3*RW +: RW]), 64'h1000);
    check("t1_model_key", 64'(exp_key_vec()), 64'(4'b1000));

    // Fill all voices: retrigger 60, then 62, 64, 67 land on 2, 1, 0.
    send(1'b1, 7'd60, 32'h1000);
    send(1'b1, 7'd62, 32'h1200);
    send(1'b1, 7'd64, 32'h1400);
    send(1'b1, 7'd67, 32'h1700);
    @(negedge clk);
    notes_full = {7'd60, 7'd62, 7'd64, 7'd67};
    check("t2_key", 64'(voice_key), 64'(4'b1111));
    check("t2_notes", 64'(voice_note), 64'(notes_full));

    send(1'b0, 7'd62, 32'h0);
    @(negedge clk);
    check("t2_off_key", 64'(voice_key), 64'(4'b1011));
    check("t2_off_note2", 64'(voice_note[2*NW +: NW]), 64'd62);
    check("t2_off_freq2", 64'(voice_freq[2*RW +: RW]), 64'h1200);

    // Refill voice 2, then request with every voice busy.
    send(1'b1, 7'd62, 32'h1100);
    evt_base = evt_cnt;
    send(1'b1, 7'd72, 32'h2000);
    @(negedge clk);
    check("t3_key", 64'(voice_key), 64'(4'b1111));
    check("t3_events", 64'(evt_cnt - evt_base), 64'd1);
`ifdef VOICE_STEAL_EN
    check("t3_note3", 64'(voice_note[3*NW +: NW]), 64'd72);
    check("t3_freq3", 64'(voice_freq[3*RW +: RW]), 64'h2000);
`else
    check("t3_note3", 64'(voice_note[3*NW +: NW]), 64'd60);
    check("t3_freq3", 64'(voice_freq[3*RW +: RW]), 64'h1000);
`endif

    // Retrigger an active note with a new freq; unmatched note-off.
    send(1'b1, 7'd64, 32'h3333);
    @(negedge clk);
    check("t4_key", 64'(voice_key), 64'(4'b1111));
    check("t4_freq1", 64'(voice_freq[1*RW +: RW]), 64'h3333);
    send(1'b0, 7'd99, 32'h0);
    @(negedge clk);
    check("t4_off_key", 64'(voice_key), 64'(4'b1111));

    // Reset while a request is in flight (steal gap when stealing is built).
    chk_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_on    = 1'b1;
    req_note  = 7'd90;
    req_freq  = 32'h9000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("t5_key", 64'(voice_key), 64'(4'b0000));
    check("t5_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;

    // Restored ranks send the next note back to voice 3.
    send(1'b1, 7'd50, 32'h500);
    @(negedge clk);
    check("t5_key_after", 64'(voice_key), 64'(4'b1000));
    check("t5_freq3", 64'(voice_freq[3*RW +: RW]), 64'h500);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
